dmem_responder: RTL and testbench

//  Data-memory responder: the memory end of the load/store unit's request interface.

---
 rtl/dmem_responder_if.sv | 20 ++
 rtl/dmem_responder.sv | 70 +++++++
 tb/tb_dmem_responder.sv | 138 +++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: LSU-to-data-memory request/response bus.
interface dmem_responder_if;
  logic        req_i;
  logic [31:0] addr_i;
  logic        wen_i;
  logic [3:0]  wmask_i;
  logic [31:0] data_i;
  logic        gnt_o;
  logic        rvalid_o;
  logic [31:0] read_data_o;
  logic        err_o;
  modport master (
    output req_i, addr_i, wen_i, wmask_i, data_i,
    input  gnt_o, rvalid_o, read_data_o, err_o
  );
  modport slave (
    input  req_i, addr_i, wen_i, wmask_i, data_i,
    output gnt_o, rvalid_o, read_data_o, err_o
  );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: word RAM answering LSU loads/stores with optional wait states and range error.
module dmem_responder #(
  parameter int          DEPTH_LOG2  = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 0
) (
  input logic             clk_i,
  input logic             reset_i,
  dmem_responder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam logic [3:0] CNT_INIT = 4'(WAIT_STATES == 0 ? 0 : WAIT_STATES - 1);
  if (WAIT_STATES < 0 || WAIT_STATES > 15 || BASE_ADDR[1:0] != 2'b00) begin : g_bad_param
    $error("dmem_responder: WAIT_STATES must be 0..15 and BASE_ADDR word aligned");
  end
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [31:0] mem [2**DEPTH_LOG2];
  logic [31:0] off, fresh_data, pend_data, out_data;
  logic [DEPTH_LOG2-1:0] idx;
  logic acc, in_range, fresh_err, pend_err, out_err, unused_lsb;
  // Unsigned subtract makes addresses below BASE_ADDR wrap high and fail the range test.
  assign off = bus.addr_i - BASE_ADDR;
  assign idx = off[DEPTH_LOG2+1:2];
  assign in_range = off[31:DEPTH_LOG2+2] == '0;
  assign unused_lsb = ^off[1:0];
  assign acc = bus.req_i && bus.gnt_o;
  assign fresh_data = bus.wen_i && in_range ? mem[idx] : '0;
  assign fresh_err = !in_range;
  assign bus.gnt_o = state != WAIT;
  assign bus.rvalid_o = state == RESP;
  assign bus.read_data_o = out_data;
  assign bus.err_o = out_err;
  always_comb begin
    state_n = acc ? (WAIT_STATES == 0 ? RESP : WAIT) : state == WAIT ? (cnt == 4'd0 ? RESP : WAIT) : IDLE;
    cnt_n = acc ? CNT_INIT : (state == WAIT && cnt != 4'd0) ? cnt - 4'd1 : cnt;
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
    end
  end
  always_ff @(posedge clk_i) begin
    if (!reset_i && acc && !bus.wen_i && in_range)
      for (int n = 0; n < 4; n++)
        if (bus.wmask_i[n]) mem[idx][8*n +: 8] <= bus.data_i[8*n +: 8];
  end
  // Pending result is parked until RESP so the visible outputs hold the previous response meanwhile.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pend_data <= '0;
      pend_err <= 1'b0;
      out_data <= '0;
      out_err <= 1'b0;
    end else begin
      if (acc) begin
        pend_data <= fresh_data;
        pend_err <= fresh_err;
      end
      if (state_n == RESP) begin
        out_data <= acc ? fresh_data : pend_data;
        out_err <= acc ? fresh_err : pend_err;
      end
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed checks of dmem_responder across wait-state and depth variants.
module tb_dmem_responder;
  logic clk = 1'b0;
  logic r0 = 1'b1, r3 = 1'b1, r4 = 1'b1, r2 = 1'b1;
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  dmem_responder_if b0 ();
  dmem_responder_if b3 ();
  dmem_responder_if b4 ();
  dmem_responder_if b2 ();
  dmem_responder #(.WAIT_STATES(0)) u0 (.clk_i(clk), .reset_i(r0), .bus(b0));
  dmem_responder #(.WAIT_STATES(3)) u3 (.clk_i(clk), .reset_i(r3), .bus(b3));
  dmem_responder #(.DEPTH_LOG2(4), .WAIT_STATES(0)) u4 (.clk_i(clk), .reset_i(r4), .bus(b4));
  dmem_responder #(.WAIT_STATES(2)) u2 (.clk_i(clk), .reset_i(r2), .bus(b2));
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask
  task automatic step(int n = 1);
    repeat (n) @(negedge clk);
  endtask
  task automatic d0(logic r, logic [31:0] a, logic w, logic [3:0] m, logic [31:0] d);
    b0.req_i = r; b0.addr_i = a; b0.wen_i = w; b0.wmask_i = m; b0.data_i = d;
  endtask
  task automatic d3(logic r, logic [31:0] a, logic w, logic [3:0] m, logic [31:0] d);
    b3.req_i = r; b3.addr_i = a; b3.wen_i = w; b3.wmask_i = m; b3.data_i = d;
  endtask
  task automatic d4(logic r, logic [31:0] a, logic w, logic [3:0] m, logic [31:0] d);
    b4.req_i = r; b4.addr_i = a; b4.wen_i = w; b4.wmask_i = m; b4.data_i = d;
  endtask
  task automatic d2(logic r, logic [31:0] a, logic w, logic [3:0] m, logic [31:0] d);
    b2.req_i = r; b2.addr_i = a; b2.wen_i = w; b2.wmask_i = m; b2.data_i = d;
  endtask
  initial begin
    d0(0, 0, 1, 0, 0); d3(0, 0, 1, 0, 0); d4(0, 0, 1, 0, 0); d2(0, 0, 1, 0, 0);
    step(2);
    chk("rst_gnt", 32'(b0.gnt_o), 32'd1);
    chk("rst_rvalid", 32'(b0.rvalid_o), 32'd0);
    chk("rst_rdata", b0.read_data_o, 32'h0);
    chk("rst_err", 32'(b0.err_o), 32'd0);
    r0 = 1'b0; r3 = 1'b0; r4 = 1'b0; r2 = 1'b0;
    step;
    // single-cycle store then load of the same word
    d0(1, 32'h10, 0, 4'hF, 32'hDEADBEEF); step;
    chk("t1_st_rvalid", 32'(b0.rvalid_o), 32'd1);
    chk("t1_st_rdata", b0.read_data_o, 32'h0);
    chk("t1_st_err", 32'(b0.err_o), 32'd0);
    d0(1, 32'h10, 1, 4'h0, 32'h0); step;
    chk("t1_ld_rvalid", 32'(b0.rvalid_o), 32'd1);
    chk("t1_ld_rdata", b0.read_data_o, 32'hDEADBEEF);
    chk("t1_ld_err", 32'(b0.err_o), 32'd0);
    d0(0, 0, 1, 0, 0); step;
    chk("t1_idle_rvalid", 32'(b0.rvalid_o), 32'd0);
    chk("t1_hold_rdata", b0.read_data_o, 32'hDEADBEEF);
    // partial-lane store
    d0(1, 32'h20, 0, 4'hF, 32'h11223344); step;
    d0(1, 32'h20, 0, 4'b0100, 32'h00AB0000); step;
    d0(1, 32'h22, 1, 4'h0, 32'h0); step;
    chk("t2_lane_rdata", b0.read_data_o, 32'h11AB3344);
    d0(0, 0, 1, 0, 0); step;
    // back-to-back loads of a split pair
    d0(1, 32'h40, 0, 4'hF, 32'hA1A2A3A4); step;
    d0(1, 32'h44, 0, 4'hF, 32'hB1B2B3B4); step;
    d0(1, 32'h40, 1, 4'h0, 32'h0);
    chk("t3_gnt_a", 32'(b0.gnt_o), 32'd1);
    step;
    chk("t3_rvalid_a", 32'(b0.rvalid_o), 32'd1);
    chk("t3_rdata_a", b0.read_data_o, 32'hA1A2A3A4);
    chk("t3_gnt_b", 32'(b0.gnt_o), 32'd1);
    d0(1, 32'h44, 1, 4'h0, 32'h0); step;
    chk("t3_rvalid_b", 32'(b0.rvalid_o), 32'd1);
    chk("t3_rdata_b", b0.read_data_o, 32'hB1B2B3B4);
    d0(0, 0, 1, 0, 0); step;
    chk("t3_rvalid_end", 32'(b0.rvalid_o), 32'd0);
    // three wait states, request during WAIT ignored
    d3(1, 32'h30, 0, 4'hF, 32'h12345678); step;
    d3(0, 0, 1, 0, 0); step(3);
    chk("t4_st_rvalid", 32'(b3.rvalid_o), 32'd1);
    d3(1, 32'h30, 1, 4'h0, 32'h0);
    chk("t4_gnt_resp", 32'(b3.gnt_o), 32'd1);
    step;
    chk("t4_gnt_w1", 32'(b3.gnt_o), 32'd0);
    chk("t4_rvalid_w1", 32'(b3.rvalid_o), 32'd0);
    chk("t4_hold_w1", b3.read_data_o, 32'h0);
    d3(1, 32'h30, 0, 4'hF, 32'hFFFFFFFF); step;
    chk("t4_gnt_w2", 32'(b3.gnt_o), 32'd0);
    d3(0, 0, 1, 0, 0); step;
    chk("t4_gnt_w3", 32'(b3.gnt_o), 32'd0);
    chk("t4_rvalid_w3", 32'(b3.rvalid_o), 32'd0);
    step;
    chk("t4_rvalid", 32'(b3.rvalid_o), 32'd1);
    chk("t4_rdata", b3.read_data_o, 32'h12345678);
    chk("t4_gnt_back", 32'(b3.gnt_o), 32'd1);
    step;
    chk("t4_rvalid_end", 32'(b3.rvalid_o), 32'd0);
    d3(1, 32'h30, 1, 4'h0, 32'h0); step;
    d3(0, 0, 1, 0, 0); step(3);
    chk("t4_ignored_st", b3.read_data_o, 32'h12345678);
    // 16-word RAM range boundaries
    d4(1, 32'h00, 0, 4'hF, 32'h0BADF00D); step;
    d4(1, 32'h3C, 0, 4'hF, 32'h3C3C3C3C); step;
    d4(1, 32'h40, 0, 4'hF, 32'hFFFFFFFF); step;
    chk("t5_oor_rvalid", 32'(b4.rvalid_o), 32'd1);
    chk("t5_oor_err", 32'(b4.err_o), 32'd1);
    chk("t5_oor_rdata", b4.read_data_o, 32'h0);
    d4(1, 32'h00, 1, 4'h0, 32'h0); step;
    chk("t5_ld0_rdata", b4.read_data_o, 32'h0BADF00D);
    chk("t5_ld0_err", 32'(b4.err_o), 32'd0);
    d4(1, 32'h3C, 1, 4'h0, 32'h0); step;
    chk("t5_top_rdata", b4.read_data_o, 32'h3C3C3C3C);
    chk("t5_top_err", 32'(b4.err_o), 32'd0);
    d4(1, 32'hFFFFFFFC, 1, 4'h0, 32'h0); step;
    chk("t5_wrap_err", 32'(b4.err_o), 32'd1);
    chk("t5_wrap_rdata", b4.read_data_o, 32'h0);
    d4(0, 0, 1, 0, 0); step;
    chk("t5_hold_err", 32'(b4.err_o), 32'd1);
    chk("t5_idle_rvalid", 32'(b4.rvalid_o), 32'd0);
    // reset during WAIT drops the response but keeps the store
    d2(1, 32'h8, 0, 4'hF, 32'h5A5A5A5A); step;
    d2(0, 0, 1, 0, 0);
    chk("t6_gnt_wait", 32'(b2.gnt_o), 32'd0);
    r2 = 1'b1; step; r2 = 1'b0;
    chk("t6_gnt_rst", 32'(b2.gnt_o), 32'd1);
    chk("t6_rvalid_rst", 32'(b2.rvalid_o), 32'd0);
    step;
    chk("t6_no_rvalid_a", 32'(b2.rvalid_o), 32'd0);
    step;
    chk("t6_no_rvalid_b", 32'(b2.rvalid_o), 32'd0);
    d2(1, 32'h8, 1, 4'h0, 32'h0); step;
    d2(0, 0, 1, 0, 0); step(2);
    chk("t6_ld_rvalid", 32'(b2.rvalid_o), 32'd1);
    chk("t6_ld_rdata", b2.read_data_o, 32'h5A5A5A5A);
    chk("t6_ld_err", 32'(b2.err_o), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
